// File: rtl/riscv_lsu_pkg.sv
// Shared funct3 access codes, FSM state encoding and access-size decode for the load/store unit.
package riscv_lsu_pkg;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } lsu_size_t;

  // Any funct3 that is not a defined code for the access direction falls back to a word.
  function automatic lsu_size_t access_size(input logic [2:0] f3, input logic is_store);
    lsu_size_t sz;
    sz = SZ_W;
    if (f3 == LSU_B || (!is_store && f3 == LSU_BU)) sz = SZ_B;
    else if (f3 == LSU_H || (!is_store && f3 == LSU_HU)) sz = SZ_H;
    return sz;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: store strobes/replicated data and load extract/extend.
module lsu_lane_align
  import riscv_lsu_pkg::*;
(
  input  lsu_size_t   size,
  input  logic        sign_ext,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_ext
);

  logic signed [7:0]  byte_sel;
  logic signed [15:0] half_sel;

  always_comb begin
    byte_sel = 8'sd0;
    case (offset)
      2'd0:    byte_sel = $signed(rdata[7:0]);
      2'd1:    byte_sel = $signed(rdata[15:8]);
      2'd2:    byte_sel = $signed(rdata[23:16]);
      default: byte_sel = $signed(rdata[31:24]);
    endcase
    half_sel = offset[1] ? $signed(rdata[31:16]) : $signed(rdata[15:0]);

    wstrb    = 4'b1111;
    wdata    = store_data;
    load_ext = rdata;
    case (size)
      SZ_B: begin
        wstrb    = 4'b0001 << offset;
        wdata    = {4{store_data[7:0]}};
        load_ext = sign_ext ? 32'(byte_sel) : {24'd0, byte_sel};
      end
      SZ_H: begin
        // Half accesses use offset[1] only; offset[0] never shifts a half lane.
        wstrb    = 4'b0011 << {offset[1], 1'b0};
        wdata    = {2{store_data[15:0]}};
        load_ext = sign_ext ? 32'(half_sel) : {16'd0, half_sel};
      end
      default: begin
        wstrb    = 4'b1111;
        wdata    = store_data;
        load_ext = rdata;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Handshaked data-memory load/store unit with core stall, timeout abort and lane alignment.
// Optional build macro MISALIGN_TRAP_EN: misaligned half/word accesses complete without a bus request.
module load_store_unit
  import riscv_lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  output logic              stall,
  output logic [31:0]       load_data,
  output logic              done,
  output logic              bus_err,
  output logic              misalign,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  lsu_state_t       state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       f3_q;
  logic [1:0]       off_q;
  logic             is_load_q;

  logic             req;
  lsu_size_t        cur_size;
  lsu_size_t        size_sel;
  logic             sext_sel;
  logic [1:0]       off_sel;
  logic             misaligned;
  logic             timeout;
  logic [3:0]       wstrb_c;
  logic [31:0]      wdata_c;
  logic [31:0]      load_ext_c;

  assign req      = mem_read | mem_write;
  assign cur_size = access_size(funct3, mem_write);
  assign timeout  = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // While idle the aligner sees the incoming instruction; while busy it sees the latched access.
  always_comb begin
    if (state == IDLE) begin
      size_sel = cur_size;
      sext_sel = ~funct3[2];
      off_sel  = addr[1:0];
    end else begin
      size_sel = access_size(f3_q, ~is_load_q);
      sext_sel = ~f3_q[2];
      off_sel  = off_q;
    end
  end

`ifdef MISALIGN_TRAP_EN
  assign misaligned = ((cur_size == SZ_H) && addr[0]) ||
                      ((cur_size == SZ_W) && (addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  lsu_lane_align u_align (
    .size       (size_sel),
    .sign_ext   (sext_sel),
    .offset     (off_sel),
    .store_data (store_data),
    .rdata      (mem_rdata),
    .wstrb      (wstrb_c),
    .wdata      (wdata_c),
    .load_ext   (load_ext_c)
  );

  always_comb begin
    state_next = state;
    stall      = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        stall = req;
        if (req) state_next = misaligned ? DONE : BUSY;
      end
      BUSY: begin
        stall = 1'b1;
        if (mem_ack || timeout) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= 4'b0000;
      load_data <= '0;
      bus_err   <= 1'b0;
      misalign  <= 1'b0;
      cnt       <= '0;
      f3_q      <= '0;
      off_q     <= '0;
      is_load_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req && misaligned) begin
            misalign  <= 1'b1;
            bus_err   <= 1'b0;
            load_data <= '0;
          end else if (req) begin
            mem_req   <= 1'b1;
            mem_we    <= mem_write;
            mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
            mem_wstrb <= mem_write ? wstrb_c : 4'b0000;
            mem_wdata <= mem_write ? wdata_c : 32'd0;
            f3_q      <= funct3;
            off_q     <= addr[1:0];
            is_load_q <= ~mem_write;
            cnt       <= '0;
            bus_err   <= 1'b0;
            misalign  <= 1'b0;
          end
        end
        BUSY: begin
          if (mem_ack) begin
            mem_req   <= 1'b0;
            load_data <= is_load_q ? load_ext_c : 32'd0;
          end else if (timeout) begin
            mem_req   <= 1'b0;
            bus_err   <= 1'b1;
            load_data <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          bus_err  <= 1'b0;
          misalign <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed vector bench for load_store_unit: table of aligned accesses plus timeout/reset/misalign sequences.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] store_data = '0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  funct3 = '0;
  logic        stall;
  logic [31:0] load_data;
  logic        done;
  logic        bus_err;
  logic        misalign;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = 32'hBAD0BAD0;
  logic        mem_ack = 1'b0;

  int total = 0;
  int bad = 0;

  load_store_unit #(.TIMEOUT_CYCLES(16), .ADDR_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .addr       (addr),
    .store_data (store_data),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .stall      (stall),
    .load_data  (load_data),
    .done       (done),
    .bus_err    (bus_err),
    .misalign   (misalign),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] sd;
    logic [31:0] rdat;
    int          waits;
    logic [31:0] exp_addr;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
    logic [31:0] exp_load;
  } vec_t;

  localparam int NV = 14;
  vec_t vt [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd);
    mem_read   = rd;
    mem_write  = wr;
    funct3     = f3;
    addr       = a;
    store_data = sd;
  endtask

  task automatic idle_inputs();
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = 32'hBAD0BAD0;
  endtask

  initial begin
    //              rd    wr    f3      addr        sdata          rdata        w  exp_addr    strb  exp_wdata      exp_load
    vt[0]  = '{1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0,        0, 32'h100, 4'hF, 32'hDEADBEEF, 32'h0};
    vt[1]  = '{1'b0, 1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h0,        0, 32'h100, 4'h8, 32'hA5A5A5A5, 32'h0};
    vt[2]  = '{1'b0, 1'b1, 3'b001, 32'h102, 32'h1234BEEF, 32'h0,        1, 32'h100, 4'hC, 32'hBEEFBEEF, 32'h0};
    vt[3]  = '{1'b0, 1'b1, 3'b000, 32'h101, 32'h00000077, 32'h0,        0, 32'h100, 4'h2, 32'h77777777, 32'h0};
    vt[4]  = '{1'b1, 1'b0, 3'b000, 32'h102, 32'h0,        32'h12F03456, 3, 32'h100, 4'h0, 32'h0,        32'hFFFFFFF0};
    vt[5]  = '{1'b1, 1'b0, 3'b100, 32'h102, 32'h0,        32'h12F03456, 3, 32'h100, 4'h0, 32'h0,        32'h000000F0};
    vt[6]  = '{1'b1, 1'b0, 3'b001, 32'h102, 32'h0,        32'h80011234, 0, 32'h100, 4'h0, 32'h0,        32'hFFFF8001};
    vt[7]  = '{1'b1, 1'b0, 3'b101, 32'h100, 32'h0,        32'h80011234, 0, 32'h100, 4'h0, 32'h0,        32'h00001234};
    vt[8]  = '{1'b1, 1'b0, 3'b001, 32'h100, 32'h0,        32'h0000F234, 0, 32'h100, 4'h0, 32'h0,        32'hFFFFF234};
    vt[9]  = '{1'b1, 1'b0, 3'b010, 32'h104, 32'h0,        32'hCAFEF00D, 2, 32'h104, 4'h0, 32'h0,        32'hCAFEF00D};
    vt[10] = '{1'b1, 1'b0, 3'b011, 32'h10C, 32'h0,        32'h89ABCDEF, 0, 32'h10C, 4'h0, 32'h0,        32'h89ABCDEF};
    vt[11] = '{1'b1, 1'b1, 3'b000, 32'h111, 32'h0000003C, 32'h0,        0, 32'h110, 4'h2, 32'h3C3C3C3C, 32'h0};
    vt[12] = '{1'b0, 1'b1, 3'b101, 32'h120, 32'h01020304, 32'h0,        0, 32'h120, 4'hF, 32'h01020304, 32'h0};
    vt[13] = '{1'b1, 1'b0, 3'b100, 32'h103, 32'h0,        32'h12F03456, 1, 32'h100, 4'h0, 32'h0,        32'h00000012};

    // Reset state
    #2;
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_bus_err", {31'd0, bus_err}, 32'd0);
    check("rst_misalign", {31'd0, misalign}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
    check("rst_load_data", load_data, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Table of aligned accesses
    for (int i = 0; i < NV; i++) begin
      issue(vt[i].rd, vt[i].wr, vt[i].f3, vt[i].a, vt[i].sd);
      #1;
      check($sformatf("v%0d_stall_req", i), {31'd0, stall}, 32'd1);
      check($sformatf("v%0d_req_idle", i), {31'd0, mem_req}, 32'd0);
      @(negedge clk);
      check($sformatf("v%0d_mem_req", i), {31'd0, mem_req}, 32'd1);
      check($sformatf("v%0d_mem_we", i), {31'd0, mem_we}, {31'd0, vt[i].wr});
      check($sformatf("v%0d_mem_addr", i), mem_addr, vt[i].exp_addr);
      if (vt[i].wr) begin
        check($sformatf("v%0d_wstrb", i), {28'd0, mem_wstrb}, {28'd0, vt[i].exp_strb});
        check($sformatf("v%0d_wdata", i), mem_wdata, vt[i].exp_wdata);
      end
      for (int w = 0; w < vt[i].waits; w++) begin
        check($sformatf("v%0d_stall_busy%0d", i, w), {31'd0, stall}, 32'd1);
        check($sformatf("v%0d_done_early%0d", i, w), {31'd0, done}, 32'd0);
        @(negedge clk);
        check($sformatf("v%0d_req_hold%0d", i, w), {31'd0, mem_req}, 32'd1);
        check($sformatf("v%0d_addr_hold%0d", i, w), mem_addr, vt[i].exp_addr);
      end
      check($sformatf("v%0d_stall_last", i), {31'd0, stall}, 32'd1);
      mem_ack   = 1'b1;
      mem_rdata = vt[i].rdat;
      @(negedge clk);
      mem_ack   = 1'b0;
      mem_rdata = 32'hBAD0BAD0;
      check($sformatf("v%0d_done", i), {31'd0, done}, 32'd1);
      check($sformatf("v%0d_stall_done", i), {31'd0, stall}, 32'd0);
      check($sformatf("v%0d_req_drop", i), {31'd0, mem_req}, 32'd0);
      check($sformatf("v%0d_bus_err", i), {31'd0, bus_err}, 32'd0);
      if (!vt[i].wr) check($sformatf("v%0d_load_data", i), load_data, vt[i].exp_load);
      idle_inputs();
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", i), {31'd0, done}, 32'd0);
    end

    // Ack with no access outstanding is ignored
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    check("stray_ack_done", {31'd0, done}, 32'd0);
    check("stray_ack_req", {31'd0, mem_req}, 32'd0);
    @(negedge clk);
    check("stray_ack_done2", {31'd0, done}, 32'd0);

    // Timeout: load never acknowledged; load_data held nonzero from previous load
    begin
      int  busy_n;
      bit  got_done;
      busy_n   = 0;
      got_done = 1'b0;
      issue(1'b1, 1'b0, 3'b010, 32'h200, 32'h0);
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (done) begin
          got_done = 1'b1;
          break;
        end
        busy_n++;
      end
      check("to_done_seen", {31'd0, got_done}, 32'd1);
      check("to_busy_cycles", busy_n, 32'd16);
      check("to_bus_err", {31'd0, bus_err}, 32'd1);
      check("to_load_data", load_data, 32'd0);
      check("to_req_drop", {31'd0, mem_req}, 32'd0);
      idle_inputs();
      @(negedge clk);
      check("to_bus_err_clear", {31'd0, bus_err}, 32'd0);
      check("to_done_clear", {31'd0, done}, 32'd0);
    end

    // Reset during BUSY aborts immediately
    issue(1'b1, 1'b0, 3'b010, 32'h300, 32'h0);
    @(negedge clk);
    check("rb_mem_req_busy", {31'd0, mem_req}, 32'd1);
    reset = 1'b1;
    #1;
    check("rb_mem_req_async", {31'd0, mem_req}, 32'd0);
    check("rb_mem_addr", mem_addr, 32'd0);
    check("rb_idle_stall", {31'd0, stall}, 32'd1);
    idle_inputs();
    #1;
    check("rb_idle_nostall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("rb_no_done%0d", k), {31'd0, done}, 32'd0);
    end

    // Misaligned word load
    issue(1'b1, 1'b0, 3'b010, 32'h101, 32'h0);
    @(negedge clk);
`ifdef MISALIGN_TRAP_EN
    check("ma_no_req", {31'd0, mem_req}, 32'd0);
    check("ma_done", {31'd0, done}, 32'd1);
    check("ma_misalign", {31'd0, misalign}, 32'd1);
    check("ma_load_data", load_data, 32'd0);
    check("ma_stall", {31'd0, stall}, 32'd0);
    idle_inputs();
    @(negedge clk);
    check("ma_misalign_clear", {31'd0, misalign}, 32'd0);
`else
    check("ma_req", {31'd0, mem_req}, 32'd1);
    check("ma_addr", mem_addr, 32'h100);
    mem_ack   = 1'b1;
    mem_rdata = 32'h5A5AC3C3;
    @(negedge clk);
    idle_inputs();
    check("ma_done", {31'd0, done}, 32'd1);
    check("ma_misalign", {31'd0, misalign}, 32'd0);
    check("ma_load_data", load_data, 32'h5A5AC3C3);
    @(negedge clk);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
